exc_ctrl: RTL and testbench

- MEM-stage exception resolver. It is the producer side of the CP0 exception interface: it drives except_type/pc/is_in_delayslot into the CP0 register block and consumes CP0 status/cause/epc back.
- Merges per-instruction exception flags with pending interrupts, picks the highest-priority exception, and produces the pipeline flush and the redirect PC.
- Bypasses an in-flight WB-stage mtc0 write to status/cause/epc, so decisions never use stale CP0 values.

---
 rtl/exc_pkg.sv | 51 +++++
 rtl/exc_prio_enc.sv | 25 ++
 rtl/exc_ctrl.sv | 151 +++++++++++++++
 tb/tb_exc_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the MEM-stage exception resolver.
//   - except_type codes driven to CP0
//   - CP0 register addresses used for mtc0 bypass
//   - status register bit positions
//   - exc_state_t FSM encoding
//   - exc_stat_idx(): maps an except_type code to its statistics slot
package exc_pkg;

   localparam logic [31:0] EXC_NONE     = 32'h0;
   localparam logic [31:0] EXC_INT      = 32'h1;
   localparam logic [31:0] EXC_INVALID  = 32'ha;
   localparam logic [31:0] EXC_SYSCALL  = 32'h8;
   localparam logic [31:0] EXC_TRAP     = 32'hd;
   localparam logic [31:0] EXC_OVERFLOW = 32'hc;
   localparam logic [31:0] EXC_ERET     = 32'he;

   // exc_flags_i bit positions
   localparam int unsigned FLAG_INVALID  = 4;
   localparam int unsigned FLAG_SYSCALL  = 3;
   localparam int unsigned FLAG_TRAP     = 2;
   localparam int unsigned FLAG_OVERFLOW = 1;
   localparam int unsigned FLAG_ERET     = 0;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam int unsigned STATUS_IE    = 0;
   localparam int unsigned STATUS_EXL   = 1;
   localparam int unsigned STATUS_IM_LO = 8;
   localparam int unsigned STATUS_IM_HI = 15;

   typedef enum logic {IDLE, FLUSH} exc_state_t;

   // Statistics slot order: int, invalid, syscall, trap, overflow, eret
   function automatic logic [2:0] exc_stat_idx(input logic [31:0] code);
      logic [2:0] idx;
      idx = 3'd0;
      case (code)
         EXC_INT:      idx = 3'd0;
         EXC_INVALID:  idx = 3'd1;
         EXC_SYSCALL:  idx = 3'd2;
         EXC_TRAP:     idx = 3'd3;
         EXC_OVERFLOW: idx = 3'd4;
         EXC_ERET:     idx = 3'd5;
         default:      idx = 3'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: combinational priority encoder for exception sources.
// Ports:
//   i_int   - interrupt to be taken (already qualified)
//   i_flags - {inst_invalid, syscall, trap, overflow, eret}
//   o_code  - except_type code of the highest-priority active source, 0 if none
// Priority: interrupt > invalid > syscall > trap > overflow > eret.
module exc_prio_enc
   import exc_pkg::*;
(
   input  logic        i_int,
   input  logic [4:0]  i_flags,
   output logic [31:0] o_code
);

   always_comb begin
      o_code = EXC_NONE;
      if (i_int)                         o_code = EXC_INT;
      else if (i_flags[FLAG_INVALID])    o_code = EXC_INVALID;
      else if (i_flags[FLAG_SYSCALL])    o_code = EXC_SYSCALL;
      else if (i_flags[FLAG_TRAP])       o_code = EXC_TRAP;
      else if (i_flags[FLAG_OVERFLOW])   o_code = EXC_OVERFLOW;
      else if (i_flags[FLAG_ERET])       o_code = EXC_ERET;
   end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception resolver, producer side of the CP0 exception interface.
// Merges instruction exception flags with pending interrupts, picks the winner,
// then flushes IF..MEM for FLUSH_CYCLES cycles and supplies the redirect PC.
// Ports:
//   clk, rst (async, active-low)
//   mem_valid_i, stall_i, mem_pc_i, mem_in_delayslot_i, exc_flags_i - MEM instruction
//   cp0_status_i, cp0_cause_i, cp0_epc_i                           - CP0 register values
//   wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i                     - in-flight WB mtc0
//   except_type_o, pc_o, is_in_delayslot_o                         - to CP0
//   flush_o, new_pc_o, int_pending_o                               - pipeline control
// Optional: define EXC_CTRL_STATS_EN to add exc_cnt_o, six 16-bit saturating
// per-exception counters packed int [15:0] .. eret [95:80].
module exc_ctrl
   import exc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic        stall_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [4:0]  exc_flags_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [31:0] except_type_o,
   output logic [31:0] pc_o,
   output logic        is_in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        int_pending_o
`ifdef EXC_CTRL_STATS_EN
   ,
   output logic [95:0] exc_cnt_o
`endif
);

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   exc_state_t  r_state;
   logic [2:0]  r_cnt;
   logic        r_flush;
   logic [31:0] r_new_pc;
   logic        r_int_pending;

   logic [31:0] w_eff_status;
   logic [7:0]  w_eff_ip;
   logic [31:0] w_eff_epc;
   logic        w_int_cond;
   logic        w_accept;
   logic        w_fire;
   logic [31:0] w_code;
   logic        w_unused_bits;

   // Bypass the WB mtc0 so decisions see the value CP0 is about to hold.
   // Only the software-writable cause bits 9:8 are bypassed; 15:10 are hardware lines.
   always_comb begin
      w_eff_status = cp0_status_i;
      w_eff_ip     = cp0_cause_i[15:8];
      w_eff_epc    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         unique case (wb_cp0_waddr_i)
            CP0_STATUS: w_eff_status = wb_cp0_data_i;
            CP0_CAUSE:  w_eff_ip[1:0] = wb_cp0_data_i[9:8];
            CP0_EPC:    w_eff_epc = wb_cp0_data_i;
            default: ;
         endcase
      end
   end

   assign w_int_cond = w_eff_status[STATUS_IE] & ~w_eff_status[STATUS_EXL]
                     & |(w_eff_ip & w_eff_status[STATUS_IM_HI:STATUS_IM_LO]);

   assign w_accept = (r_state == IDLE) & mem_valid_i & ~stall_i;

   // Gating the sources with accept forces a zero code during FLUSH, stalls and bubbles.
   // Requiring both the registered and the live condition lets a same-cycle mtc0
   // that masks interrupts win.
   exc_prio_enc u_prio_enc (
      .i_int   (w_accept & r_int_pending & w_int_cond),
      .i_flags (exc_flags_i & {5{w_accept}}),
      .o_code  (w_code)
   );

   assign except_type_o     = w_code;
   assign pc_o              = mem_pc_i;
   assign is_in_delayslot_o = mem_in_delayslot_i;
   assign flush_o           = r_flush;
   assign new_pc_o          = r_new_pc;
   assign int_pending_o     = r_int_pending;

   assign w_fire = w_accept & (w_code != EXC_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_cnt         <= 3'd0;
         r_flush       <= 1'b0;
         r_new_pc      <= 32'h0;
         r_int_pending <= 1'b0;
      end else begin
         r_int_pending <= w_int_cond;
         unique case (r_state)
            IDLE: begin
               if (w_fire) begin
                  r_state  <= FLUSH;
                  r_flush  <= 1'b1;
                  r_new_pc <= (w_code == EXC_ERET) ? w_eff_epc : EXC_VECTOR;
                  r_cnt    <= FLUSH_LAST;
               end
            end
            FLUSH: begin
               if (r_cnt == 3'd0) begin
                  r_flush <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef EXC_CTRL_STATS_EN
   logic [15:0] r_stat [6];
   logic [2:0]  w_stat_idx;

   assign w_stat_idx = exc_stat_idx(w_code);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 6; i++) r_stat[i] <= 16'h0;
      end else if (w_fire && (r_stat[w_stat_idx] != 16'hFFFF)) begin
         r_stat[w_stat_idx] <= r_stat[w_stat_idx] + 16'd1;
      end
   end

   assign exc_cnt_o = {r_stat[5], r_stat[4], r_stat[3], r_stat[2], r_stat[1], r_stat[0]};
`endif

   assign w_unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2], cp0_cause_i[31:16],
                            cp0_cause_i[7:0], w_eff_status[31:16], w_eff_status[7:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: self-checking bench for exc_ctrl. Two instances (FLUSH_CYCLES 1 and 3)
// share stimulus; a behavioural model tracks each one and is compared every cycle.
module tb_exc_ctrl;

   localparam logic [31:0] VEC = 32'hBFC00380;
   localparam logic [31:0] ST_DEF = 32'h10400000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid, stall, ds, wb_we;
   logic [31:0] pc, status, cause, epc, wb_data;
   logic [4:0]  flags, wb_addr;

   logic [31:0] et [2];
   logic [31:0] pco [2];
   logic        dso [2];
   logic        fl [2];
   logic [31:0] npc [2];
   logic        ip [2];
`ifdef EXC_CTRL_STATS_EN
   logic [95:0] cnt [2];
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_valid_i(valid), .stall_i(stall), .mem_pc_i(pc),
      .mem_in_delayslot_i(ds), .exc_flags_i(flags), .cp0_status_i(status),
      .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr),
      .wb_cp0_data_i(wb_data), .except_type_o(et[0]), .pc_o(pco[0]),
      .is_in_delayslot_o(dso[0]), .flush_o(fl[0]), .new_pc_o(npc[0]),
      .int_pending_o(ip[0])
`ifdef EXC_CTRL_STATS_EN
      , .exc_cnt_o(cnt[0])
`endif
   );

   exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .mem_valid_i(valid), .stall_i(stall), .mem_pc_i(pc),
      .mem_in_delayslot_i(ds), .exc_flags_i(flags), .cp0_status_i(status),
      .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr),
      .wb_cp0_data_i(wb_data), .except_type_o(et[1]), .pc_o(pco[1]),
      .is_in_delayslot_o(dso[1]), .flush_o(fl[1]), .new_pc_o(npc[1]),
      .int_pending_o(ip[1])
`ifdef EXC_CTRL_STATS_EN
      , .exc_cnt_o(cnt[1])
`endif
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   int          fcv [2] = '{1, 3};
   int          m_busy [2];       // flush cycles still to come (flush_o high while > 0)
   logic        m_pend [2];
   logic [31:0] m_npc [2];
   int          m_cnt [2][6];

   function automatic logic [31:0] exp_code(input logic acc, input logic take_int,
                                             input logic [4:0] f);
      if (!acc)          return 32'h0;
      if (take_int)      return 32'h1;
      if (f[4])          return 32'ha;
      if (f[3])          return 32'h8;
      if (f[2])          return 32'hd;
      if (f[1])          return 32'hc;
      if (f[0])          return 32'he;
      return 32'h0;
   endfunction

   function automatic int code_idx(input logic [31:0] c);
      case (c)
         32'h1: return 0;
         32'ha: return 1;
         32'h8: return 2;
         32'hd: return 3;
         32'hc: return 4;
         default: return 5;
      endcase
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 0; m_pend[d] = 1'b0; m_npc[d] = 32'h0;
         for (int k = 0; k < 6; k++) m_cnt[d][k] = 0;
      end
   end

   always @(negedge clk) begin : compare
      logic [31:0] es, ee, ec;
      logic [7:0]  eip;
      logic        icond, acc, ti;
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_pend[d] = 1'b0; m_npc[d] = 32'h0;
            for (int k = 0; k < 6; k++) m_cnt[d][k] = 0;
         end
      end
      es  = (wb_we && wb_addr == 5'd12) ? wb_data : status;
      ee  = (wb_we && wb_addr == 5'd14) ? wb_data : epc;
      eip = cause[15:8];
      if (wb_we && wb_addr == 5'd13) eip[1:0] = wb_data[9:8];
      icond = es[0] && !es[1] && ((eip & es[15:8]) != 8'h0);
      for (int d = 0; d < 2; d++) begin
         acc = (m_busy[d] == 0) && valid && !stall;
         ti  = m_pend[d] && icond;
         ec  = exp_code(acc, ti, flags);
         check($sformatf("m%0d.except_type", d), 96'(et[d]), 96'(ec));
         check($sformatf("m%0d.pc", d), 96'(pco[d]), 96'(pc));
         check($sformatf("m%0d.delayslot", d), 96'(dso[d]), 96'(ds));
         check($sformatf("m%0d.flush", d), 96'(fl[d]), 96'(m_busy[d] > 0));
         check($sformatf("m%0d.new_pc", d), 96'(npc[d]), 96'(m_npc[d]));
         check($sformatf("m%0d.int_pending", d), 96'(ip[d]), 96'(m_pend[d]));
`ifdef EXC_CTRL_STATS_EN
         for (int k = 0; k < 6; k++)
            check($sformatf("m%0d.cnt%0d", d, k), 96'(cnt[d][k*16 +: 16]), 96'(m_cnt[d][k]));
`endif
         if (rst) begin
            m_pend[d] = icond;
            if (m_busy[d] > 0) m_busy[d]--;
            else if (ec != 32'h0) begin
               m_busy[d] = fcv[d];
               m_npc[d]  = (ec == 32'he) ? ee : VEC;
               if (m_cnt[d][code_idx(ec)] < 65535) m_cnt[d][code_idx(ec)]++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic defaults();
      valid = 1'b0; stall = 1'b0; ds = 1'b0; pc = 32'h80000000; flags = 5'b0;
      status = ST_DEF; cause = 32'h0; epc = 32'h0;
      wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
   endtask

   initial begin
      defaults();
      repeat (3) step();
      check("reset.flush", 96'(fl[0]), 96'(0));
      check("reset.new_pc", 96'(npc[0]), 96'(0));
      check("reset.int_pending", 96'(ip[1]), 96'(0));
      step();
      rst = 1'b1;

      // syscall
      step();
      valid = 1'b1; pc = 32'h80000100; flags = 5'b01000;
      #2 check("syscall.type", 96'(et[0]), 96'(32'h8));
      step();
      check("syscall.flush", 96'(fl[0]), 96'(1));
      check("syscall.new_pc", 96'(npc[0]), 96'(VEC));
      valid = 1'b0; flags = 5'b0;
      step();
      check("syscall.flush_drop", 96'(fl[0]), 96'(0));
      repeat (3) step();

      // eret with epc bypass
      epc = 32'h80001000; wb_we = 1'b1; wb_addr = 5'd14; wb_data = 32'h80002000;
      flags = 5'b00001; valid = 1'b1;
      #2 check("eret.type", 96'(et[0]), 96'(32'he));
      step();
      check("eret.new_pc", 96'(npc[0]), 96'(32'h80002000));
      check("eret.new_pc3", 96'(npc[1]), 96'(32'h80002000));
      defaults();
      repeat (4) step();

      // interrupt
      status = 32'h00000401; cause = 32'h00000400;
      #2 check("int.not_yet", 96'(ip[0]), 96'(0));
      step();
      check("int.pending", 96'(ip[0]), 96'(1));
      valid = 1'b1;
      #2 check("int.type", 96'(et[0]), 96'(32'h1));
      step();
      check("int.flush", 96'(fl[0]), 96'(1));
      valid = 1'b0;
      repeat (4) step();
      valid = 1'b1; wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'h00000400;
      #2 check("int.mtc0_masks", 96'(et[0]), 96'(0));
      defaults();
      repeat (4) step();

      // priority and stall
      status = 32'h00000401; cause = 32'h00000400;
      step();
      valid = 1'b1; flags = 5'b11110;
      #2 check("prio.int_wins", 96'(et[0]), 96'(32'h1));
      step();
      valid = 1'b0; status = ST_DEF; cause = 32'h0;
      repeat (4) step();
      valid = 1'b1; stall = 1'b1;
      #2 check("prio.stall0", 96'(et[0]), 96'(0));
      step();
      check("prio.stall1", 96'(et[0]), 96'(0));
      stall = 1'b0;
      #2 check("prio.invalid", 96'(et[0]), 96'(32'ha));
      step();
      defaults();
      repeat (4) step();

      // back-to-back faults against FLUSH_CYCLES=3
      valid = 1'b1; flags = 5'b01000;
      #2 check("b2b.first", 96'(et[1]), 96'(32'h8));
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("b2b.flush%0d", i), 96'(fl[1]), 96'(1));
         check($sformatf("b2b.masked%0d", i), 96'(et[1]), 96'(0));
      end
      step();
      check("b2b.flush_end", 96'(fl[1]), 96'(0));
      check("b2b.second", 96'(et[1]), 96'(32'h8));
      defaults();
      repeat (4) step();

      // reset in the 2nd FLUSH cycle
      valid = 1'b1; flags = 5'b00100;
      step();
      defaults();
      step();
      #1 rst = 1'b0;
      #1 check("rst_mid.flush", 96'(fl[1]), 96'(0));
      check("rst_mid.new_pc", 96'(npc[1]), 96'(0));
      step();
      rst = 1'b1;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         rst     = ($urandom_range(0, 199) != 0);
         valid   = ($urandom_range(0, 4) != 0);
         stall   = ($urandom_range(0, 4) == 0);
         ds      = 1'($urandom);
         pc      = $urandom;
         flags   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
         status  = {16'($urandom), 8'($urandom), 6'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
         cause   = $urandom;
         epc     = $urandom;
         wb_we   = ($urandom_range(0, 3) == 0);
         wb_addr = 5'($urandom_range(11, 15));
         wb_data = $urandom;
      end
      step();
      rst = 1'b1;
      defaults();
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
